// File: rtl/serial_to_parallel.sv
// serial_to_parallel: LSB-first serial-in / parallel-out deserializer.
// Rebuilds WIDTH-bit frames from a qualified serial stream and hands each word
// to a one-entry output buffer guarded by a valid/ready handshake.
// Sticky flags report dropped words (overrun) and frames cut short by a new
// start (sync_err).
// Optional feature macro: S2P_PARITY_EN (one even-parity bit trails each frame;
// par_err reports the check result for the buffered word).
module serial_to_parallel #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             s_start,
  output logic [WIDTH-1:0] p_data,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             overrun,
  output logic             sync_err,
  output logic             par_err
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef S2P_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [WIDTH-1:0]   shreg, shreg_next;
  logic [WIDTH-1:0]   word;
  logic               done;
  logic               sync_hit;
`ifdef S2P_PARITY_EN
  logic               par_bad;
  logic               par_err_q;
`endif

  // Next-state, bit placement and frame-completion decode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next = state;
    cnt_next   = cnt;
    shreg_next = shreg;
    word       = shreg;
    done       = 1'b0;
    sync_hit   = 1'b0;
`ifdef S2P_PARITY_EN
    par_bad    = 1'b0;
`endif
    if (s_valid) begin
      if (s_start) begin
        // A start always opens a new frame; mid-frame it also aborts the old one.
        sync_hit      = (state != IDLE);
        shreg_next    = '0;
        shreg_next[0] = s_in;
        cnt_next      = CNT_W'(1);
        state_next    = SHIFT;
      end else begin
        case (state)
          IDLE: state_next = IDLE;  // stray bit outside a frame is ignored
          SHIFT: begin
            shreg_next[cnt] = s_in;
            cnt_next        = cnt + 1'b1;
            if (cnt == LAST) begin
              cnt_next = '0;
`ifdef S2P_PARITY_EN
              state_next = PAR;
`else
              state_next = IDLE;
              done       = 1'b1;
              word       = shreg_next;
`endif
            end
          end
`ifdef S2P_PARITY_EN
          PAR: begin
            state_next = IDLE;
            done       = 1'b1;
            word       = shreg;
            par_bad    = ^{shreg, s_in};
          end
`endif
          default: state_next = IDLE;
        endcase
      end
    end
  end

  // State register, deserializer storage, output buffer and sticky flags.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      p_data   <= '0;
      p_valid  <= 1'b0;
      overrun  <= 1'b0;
      sync_err <= 1'b0;
`ifdef S2P_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      shreg <= shreg_next;
      if (sync_hit) sync_err <= 1'b1;
      if (done) begin
        // Load when empty, or when the held word leaves in this same cycle.
        if (!p_valid || p_ready) begin
          p_data  <= word;
          p_valid <= 1'b1;
`ifdef S2P_PARITY_EN
          par_err_q <= par_bad;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end else if (p_valid && p_ready) begin
        p_valid <= 1'b0;
      end
    end
  end

`ifdef S2P_PARITY_EN
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_to_parallel.sv
// tb_serial_to_parallel: directed and randomized checks of the deserializer
// against a frame-level reference model built on a queue of received bits.
module tb_serial_to_parallel;

  localparam int WIDTH = 4;
`ifdef S2P_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_LEN = WIDTH + PAR_BITS;

  logic             clk = 1'b0;
  logic             reset, s_in, s_valid, s_start, p_ready;
  logic [WIDTH-1:0] p_data;
  logic             p_valid, overrun, sync_err, par_err;

  serial_to_parallel #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .s_in(s_in), .s_valid(s_valid), .s_start(s_start),
    .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready),
    .overrun(overrun), .sync_err(sync_err), .par_err(par_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state.
  logic             rx_q[$];
  logic [WIDTH-1:0] m_data;
  logic             m_valid, m_ovr, m_sync, m_perr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the same inputs driven to the DUT.
  task automatic model(input logic rst, input logic b, input logic v,
                       input logic st, input logic rdy);
    logic             done;
    logic [WIDTH-1:0] w;
    logic             pe;
    done = 1'b0;
    w    = '0;
    pe   = 1'b0;
    if (rst) begin
      rx_q.delete();
      m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; m_sync = 1'b0; m_perr = 1'b0;
      return;
    end
    if (v) begin
      if (st) begin
        if (rx_q.size() != 0) m_sync = 1'b1;
        rx_q.delete();
        rx_q.push_back(b);
      end else if (rx_q.size() != 0) begin
        rx_q.push_back(b);
      end
      if (rx_q.size() == FRAME_LEN) begin
        done = 1'b1;
        for (int i = 0; i < WIDTH; i++) w = w + (WIDTH'(rx_q[i]) << i);
        for (int i = 0; i < FRAME_LEN; i++) pe = pe ^ rx_q[i];
        rx_q.delete();
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_data = w; m_valid = 1'b1;
        if (PAR_BITS != 0) m_perr = pe;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  // Drive one cycle, update the model, then compare all outputs after the edge.
  task automatic step(input logic rst, input logic b, input logic v,
                      input logic st, input logic rdy);
    reset = rst; s_in = b; s_valid = v; s_start = st; p_ready = rdy;
    model(rst, b, v, st, rdy);
    @(posedge clk);
    #1;
    check("p_valid",  32'(p_valid),  32'(m_valid));
    check("p_data",   32'(p_data),   32'(m_data));
    check("overrun",  32'(overrun),  32'(m_ovr));
    check("sync_err", 32'(sync_err), 32'(m_sync));
    check("par_err",  32'(par_err),  32'(m_perr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  // One full frame; p_ready is raised only on the completing bit.
  task automatic send_frame(input logic [WIDTH-1:0] w, input int gap_max,
                            input logic rdy_last, input logic bad_par);
    for (int i = 0; i < FRAME_LEN; i++) begin
      logic b;
      b = (i < WIDTH) ? w[i] : ((^w) ^ bad_par);
      step(1'b0, b, 1'b1, (i == 0), (i == FRAME_LEN - 1) ? rdy_last : 1'b0);
      if (gap_max > 0 && i < FRAME_LEN - 1) idle(int'($urandom_range(gap_max, 1)));
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; s_in = 1'b0; s_valid = 1'b0; s_start = 1'b0; p_ready = 1'b0;
    do_reset();
    check("reset_p_valid", 32'(p_valid), 32'd0);
    check("reset_p_data",  32'(p_data),  32'd0);

    // Back-to-back frame 0xB, no consumer.
    send_frame(4'hB, 0, 1'b0, 1'b0);
    check("t1_data",  32'(p_data),  32'hB);
    check("t1_valid", 32'(p_valid), 32'd1);
    idle(2);

    // Gapped frame with stray unqualified bits in IDLE.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(4'hB, 3, 1'b0, 1'b0);
    check("t2_data", 32'(p_data), 32'hB);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Overrun with full buffer, then drain.
    do_reset();
    send_frame(4'h3, 0, 1'b0, 1'b0);
    send_frame(4'h5, 1, 1'b0, 1'b0);
    check("t3_data",    32'(p_data),  32'h3);
    check("t3_overrun", 32'(overrun), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_drained", 32'(p_valid), 32'd0);

    // Simultaneous transfer-out and load.
    do_reset();
    send_frame(4'hA, 0, 1'b0, 1'b0);
    send_frame(4'h6, 2, 1'b1, 1'b0);
    check("t4_data",    32'(p_data),  32'h6);
    check("t4_valid",   32'(p_valid), 32'd1);
    check("t4_overrun", 32'(overrun), 32'd0);

    // Aborted frame, then reset mid-frame.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(4'hC, 0, 1'b0, 1'b0);
    check("t5_sync", 32'(sync_err), 32'd1);
    check("t5_data", 32'(p_data),   32'hC);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_reset();
    check("t5_rst_valid", 32'(p_valid),  32'd0);
    check("t5_rst_sync",  32'(sync_err), 32'd0);
    send_frame(4'h9, 0, 1'b0, 1'b0);
    check("t5_data9", 32'(p_data), 32'h9);

    // Parity: good then bad parity bit.
    do_reset();
    send_frame(4'hB, 0, 1'b0, 1'b0);
    check("t6_good", 32'(par_err), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(4'hB, 0, 1'b0, 1'b1);
`ifdef S2P_PARITY_EN
    check("t6_bad", 32'(par_err), 32'd1);
`else
    check("t6_bad", 32'(par_err), 32'd0);
`endif

    // Random traffic: gaps, stray bits, aborts, backpressure, rare resets.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic v, st, rdy, rst;
      v   = ($urandom_range(3, 0) != 0);
      st  = v && ($urandom_range(5, 0) == 0);
      rdy = ($urandom_range(2, 0) == 0);
      rst = ($urandom_range(199, 0) == 0);
      step(rst, 1'($urandom), v, st, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
